ecc_point_ctrl: RTL
===================

Name: ecc_point_ctrl

Overview:
- Sequencer that drives the GF(p) arithmetic unit from the control side. It issues add, sub, mult and div micro-operations over the unit's start/done handshake and collects the results.
- Computes one affine elliptic-curve point addition or point doubling over GF(p): R = P1 + P2, or R = 2·P1.
- Sits between the top-level scalar-multiplication loop and the arithmetic unit.
- Owns the temporaries lam, t0 and t1. The arithmetic unit is used strictly one operation at a time.

Parameters:
- SIZE, 32, field element width; must match the arithmetic unit.
- TIMEOUT, 4096, maximum cycles to wait for gf_done per micro-op before aborting with err.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; operands sampled on this cycle.
- dbl  in  1  1 = doubling (P2 ignored), 0 = addition.
- x1, y1, x2, y2  in  SIZE each  input point coordinates, each < prime.
- a_coef  in  SIZE  curve coefficient a.
- prime  in  SIZE  field modulus; forwarded unchanged, must stay stable while busy.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse; x3, y3, inf, err are valid on this cycle and held until the next accepted start.
- x3, y3  out  SIZE each  result point.
- inf  out  1  result is the point at infinity (x3 = y3 = 0).
- err  out  1  aborted on timeout.
- gf_in_0, gf_in_1  out  SIZE each  operands to the arithmetic unit.
- gf_op  out  2  0 = add, 1 = sub, 2 = mult, 3 = div (gf_in_0 · gf_in_1⁻¹).
- gf_start  out  1  drives the unit's done_from_control; one-cycle pulse.
- gf_result  in  SIZE  result from the unit.
- gf_done  in  1  the unit's done_to_control; gf_result is valid on this cycle.

Behaviour:
- Reset (async, any state including mid-operation):
  - Outputs: busy, done, inf, err, gf_start = 0; x3, y3, gf_in_0, gf_in_1 = 0; gf_op = 0.
  - Internal: registers cleared, FSM to IDLE, step = 0.
  - An in-flight unit operation is abandoned; its gf_done is ignored.
- State machine: IDLE, CHECK, ISSUE, WAIT, DONE. All outputs are registered.
- IDLE:
  - On start: latch all inputs into internal registers, go to CHECK.
  - start while not in IDLE is ignored.
- CHECK (1 cycle):
  - Add, x1 == x2, y1 != y2: inf = 1, go to DONE with no unit ops.
  - Add, x1 == x2, y1 == y2: treat as doubling.
  - Doubling with y1 == 0: inf = 1, go to DONE.
  - Otherwise: step = 0, go to ISSUE.
- ISSUE (1 cycle):
  - Drive gf_op, gf_in_0, gf_in_1 for the current step and pulse gf_start.
  - Go to WAIT with watchdog cleared.
  - gf_op and the operands stay stable from ISSUE until gf_done is received.
- WAIT:
  - On gf_done: write gf_result to the step's destination.
  - If it was the last step, go to DONE; else step + 1, go to ISSUE.
  - Back-to-back rate: one idle cycle between gf_done and the next gf_start.
  - Watchdog reaches TIMEOUT: err = 1, go to DONE; x3/y3 keep their previous values.
  - gf_done in any other state is ignored.
- DONE (1 cycle): done = 1, busy = 0, back to IDLE. done is cleared after one cycle.
- Addition sequence, 9 steps:
  1. t0 = y2 − y1
  2. t1 = x2 − x1
  3. lam = t0 / t1
  4. t0 = lam·lam
  5. t0 = t0 − x1
  6. x3 = t0 − x2
  7. t0 = x1 − x3
  8. t0 = lam·t0
  9. y3 = t0 − y1
- Doubling sequence, 12 steps:
  1. t0 = x1·x1
  2. t1 = t0 + t0
  3. t0 = t1 + t0
  4. t0 = t0 + a
  5. t1 = y1 + y1
  6. lam = t0 / t1
  7–12. Addition steps 4–9 with x2 := x1.
- Arithmetic: the controller does no field arithmetic itself, only equality compares (x1 == x2, y1 == y2, y1 == 0).
- inf and err are cleared on each accepted start.

Test Plan:
All scenarios use a bench GFAU model with exact mod-p arithmetic, latency 3 cycles (div 40 cycles), on curve y² = x³ + 2x + 2, p = 17.
- Add (5,1) + (6,3) → done pulse with x3 = 10, y3 = 6, inf = 0; exactly 9 gf_start pulses, op order 1,1,3,2,1,1,1,2,1.
- Double (5,1) → x3 = 6, y3 = 3; 12 gf_start pulses; the first op is mult with in_0 = in_1 = 5.
- Add (5,1) + (5,16) → inf = 1, x3 = y3 = 0, done 3 cycles after start, zero gf_start pulses. Add (5,1) + (5,1) → same result as the doubling case.
- Model stops answering on step 3 → err = 1 and done exactly TIMEOUT cycles after that gf_start. Next start clears err and runs normally.
- start pulsed while busy, plus spurious gf_done pulses in ISSUE/IDLE → no effect on sequence or result. i_rst low mid-WAIT → all outputs 0 immediately; a following start computes correctly.

Source files
------------

// File: rtl/ecc_point_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ecc_point_ctrl
// Brief    : Affine EC point add/double sequencer driving a GF(p) arithmetic unit
// Revision : 1.0 - initial release
// ============================================================================
module ecc_point_ctrl #(
    parameter int SIZE    = 32,
    parameter int TIMEOUT = 4096
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            start,
    input  logic            dbl,
    input  logic [SIZE-1:0] x1,
    input  logic [SIZE-1:0] y1,
    input  logic [SIZE-1:0] x2,
    input  logic [SIZE-1:0] y2,
    input  logic [SIZE-1:0] a_coef,
    input  logic [SIZE-1:0] prime,
    output logic            busy,
    output logic            done,
    output logic [SIZE-1:0] x3,
    output logic [SIZE-1:0] y3,
    output logic            inf,
    output logic            err,
    output logic [SIZE-1:0] gf_in_0,
    output logic [SIZE-1:0] gf_in_1,
    output logic [1:0]      gf_op,
    output logic            gf_start,
    input  logic [SIZE-1:0] gf_result,
    input  logic            gf_done
);
    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_ISSUE, S_WAIT, S_DONE} state_t;
    typedef enum logic [1:0] {OP_ADD = 2'd0, OP_SUB = 2'd1, OP_MUL = 2'd2, OP_DIV = 2'd3} op_t;
    typedef enum logic [3:0] {SRC_X1, SRC_Y1, SRC_X2, SRC_Y2, SRC_A, SRC_LAM, SRC_T0, SRC_T1, SRC_X3} src_t;
    typedef enum logic [2:0] {DST_T0, DST_T1, DST_LAM, DST_X3, DST_Y3} dst_t;

    // Program layout: 0-2 addition prelude, 3-8 doubling prelude, 9-14 shared tail.
    localparam logic [3:0] STEP_ADD0     = 4'd0;
    localparam logic [3:0] STEP_ADD_LAST = 4'd2;
    localparam logic [3:0] STEP_DBL0     = 4'd3;
    localparam logic [3:0] STEP_TAIL     = 4'd9;
    localparam logic [3:0] STEP_LAST     = 4'd14;
    localparam int         WDW           = $clog2(TIMEOUT);
    // Expiry on this count lands done exactly TIMEOUT cycles after the gf_start pulse.
    localparam logic [WDW-1:0] WD_LAST   = WDW'(TIMEOUT - 2);

    state_t          state_q, state_d;
    logic [3:0]      step_q, step_d;
    logic [WDW-1:0]  wdog_q, wdog_d;
    logic [SIZE-1:0] x1_q, x1_d, y1_q, y1_d, x2_q, x2_d, y2_q, y2_d, a_q, a_d;
    logic [SIZE-1:0] lam_q, lam_d, t0_q, t0_d, t1_q, t1_d, xr_q, xr_d;
    logic            dbl_q, dbl_d;
    logic            busy_q, busy_d, done_q, done_d, inf_q, inf_d, err_q, err_d;
    logic [SIZE-1:0] x3_q, x3_d, y3_q, y3_d, gf_in_0_q, gf_in_0_d, gf_in_1_q, gf_in_1_d;
    logic [1:0]      gf_op_q, gf_op_d;
    logic            gf_start_q, gf_start_d;

    op_t  u_op;
    src_t u_s0, u_s1;
    dst_t u_dst;

    // The modulus is wired to the arithmetic unit at the level above.
    logic prime_unused;
    assign prime_unused = ^prime;

    always_comb begin
        u_op  = OP_ADD;
        u_s0  = SRC_T0;
        u_s1  = SRC_T0;
        u_dst = DST_T0;
        case (step_q)
            4'd0:  begin u_op = OP_SUB; u_s0 = SRC_Y2;  u_s1 = SRC_Y1;  u_dst = DST_T0;  end
            4'd1:  begin u_op = OP_SUB; u_s0 = SRC_X2;  u_s1 = SRC_X1;  u_dst = DST_T1;  end
            4'd2:  begin u_op = OP_DIV; u_s0 = SRC_T0;  u_s1 = SRC_T1;  u_dst = DST_LAM; end
            4'd3:  begin u_op = OP_MUL; u_s0 = SRC_X1;  u_s1 = SRC_X1;  u_dst = DST_T0;  end
            4'd4:  begin u_op = OP_ADD; u_s0 = SRC_T0;  u_s1 = SRC_T0;  u_dst = DST_T1;  end
            4'd5:  begin u_op = OP_ADD; u_s0 = SRC_T1;  u_s1 = SRC_T0;  u_dst = DST_T0;  end
            4'd6:  begin u_op = OP_ADD; u_s0 = SRC_T0;  u_s1 = SRC_A;   u_dst = DST_T0;  end
            4'd7:  begin u_op = OP_ADD; u_s0 = SRC_Y1;  u_s1 = SRC_Y1;  u_dst = DST_T1;  end
            4'd8:  begin u_op = OP_DIV; u_s0 = SRC_T0;  u_s1 = SRC_T1;  u_dst = DST_LAM; end
            4'd9:  begin u_op = OP_MUL; u_s0 = SRC_LAM; u_s1 = SRC_LAM; u_dst = DST_T0;  end
            4'd10: begin u_op = OP_SUB; u_s0 = SRC_T0;  u_s1 = SRC_X1;  u_dst = DST_T0;  end
            4'd11: begin u_op = OP_SUB; u_s0 = SRC_T0;  u_s1 = SRC_X2;  u_dst = DST_X3;  end
            4'd12: begin u_op = OP_SUB; u_s0 = SRC_X1;  u_s1 = SRC_X3;  u_dst = DST_T0;  end
            4'd13: begin u_op = OP_MUL; u_s0 = SRC_LAM; u_s1 = SRC_T0;  u_dst = DST_T0;  end
            4'd14: begin u_op = OP_SUB; u_s0 = SRC_T0;  u_s1 = SRC_Y1;  u_dst = DST_Y3;  end
            default: ;
        endcase
    end

    function automatic logic [SIZE-1:0] sel_src(input src_t s);
        case (s)
            SRC_X1:  return x1_q;
            SRC_Y1:  return y1_q;
            SRC_X2:  return x2_q;
            SRC_Y2:  return y2_q;
            SRC_A:   return a_q;
            SRC_LAM: return lam_q;
            SRC_T0:  return t0_q;
            SRC_T1:  return t1_q;
            SRC_X3:  return xr_q;
            default: return '0;
        endcase
    endfunction

    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        wdog_d     = wdog_q;
        x1_d = x1_q; y1_d = y1_q; x2_d = x2_q; y2_d = y2_q; a_d = a_q; dbl_d = dbl_q;
        lam_d = lam_q; t0_d = t0_q; t1_d = t1_q; xr_d = xr_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        inf_d      = inf_q;
        err_d      = err_q;
        x3_d       = x3_q;
        y3_d       = y3_q;
        gf_in_0_d  = gf_in_0_q;
        gf_in_1_d  = gf_in_1_q;
        gf_op_d    = gf_op_q;
        gf_start_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    x1_d = x1; y1_d = y1; x2_d = x2; y2_d = y2; a_d = a_coef; dbl_d = dbl;
                    inf_d   = 1'b0;
                    err_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if ((!dbl_q && x1_q == x2_q && y1_q != y2_q) ||
                    ((dbl_q || x1_q == x2_q) && y1_q == '0)) begin
                    inf_d   = 1'b1;
                    x3_d    = '0;
                    y3_d    = '0;
                    state_d = S_DONE;
                end else begin
                    // Equal points on the addition path fall through to doubling.
                    if (dbl_q || x1_q == x2_q) begin
                        step_d = STEP_DBL0;
                        x2_d   = x1_q;
                    end else begin
                        step_d = STEP_ADD0;
                    end
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                gf_op_d    = u_op;
                gf_in_0_d  = sel_src(u_s0);
                gf_in_1_d  = sel_src(u_s1);
                gf_start_d = 1'b1;
                wdog_d     = '0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                if (gf_done) begin
                    case (u_dst)
                        DST_T0:  t0_d  = gf_result;
                        DST_T1:  t1_d  = gf_result;
                        DST_LAM: lam_d = gf_result;
                        DST_X3:  xr_d  = gf_result;
                        DST_Y3:  y3_d  = gf_result;
                        default: ;
                    endcase
                    if (step_q == STEP_LAST) begin
                        x3_d    = xr_q;
                        state_d = S_DONE;
                    end else begin
                        step_d  = (step_q == STEP_ADD_LAST) ? STEP_TAIL : step_q + 4'd1;
                        state_d = S_ISSUE;
                    end
                end else if (wdog_q == WD_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= S_IDLE;
            step_q  <= '0;
            wdog_q  <= '0;
            x1_q <= '0; y1_q <= '0; x2_q <= '0; y2_q <= '0; a_q <= '0; dbl_q <= 1'b0;
            lam_q <= '0; t0_q <= '0; t1_q <= '0; xr_q <= '0;
            busy_q <= 1'b0; done_q <= 1'b0; inf_q <= 1'b0; err_q <= 1'b0;
            x3_q <= '0; y3_q <= '0; gf_in_0_q <= '0; gf_in_1_q <= '0;
            gf_op_q <= '0; gf_start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            wdog_q  <= wdog_d;
            x1_q <= x1_d; y1_q <= y1_d; x2_q <= x2_d; y2_q <= y2_d; a_q <= a_d; dbl_q <= dbl_d;
            lam_q <= lam_d; t0_q <= t0_d; t1_q <= t1_d; xr_q <= xr_d;
            busy_q <= busy_d; done_q <= done_d; inf_q <= inf_d; err_q <= err_d;
            x3_q <= x3_d; y3_q <= y3_d; gf_in_0_q <= gf_in_0_d; gf_in_1_q <= gf_in_1_d;
            gf_op_q <= gf_op_d; gf_start_q <= gf_start_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign inf      = inf_q;
    assign err      = err_q;
    assign x3       = x3_q;
    assign y3       = y3_q;
    assign gf_in_0  = gf_in_0_q;
    assign gf_in_1  = gf_in_1_q;
    assign gf_op    = gf_op_q;
    assign gf_start = gf_start_q;
endmodule
`default_nettype wire
